// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU op codes, divider FSM
// states and forwarding select codes.
package exec_pkg;

  // ALU / divider operation codes carried on alu_controlE
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_RSVD = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;
  localparam logic [3:0] ALU_DIVU = 4'd13;
  localparam logic [3:0] ALU_REM  = 4'd14;
  localparam logic [3:0] ALU_REMU = 4'd15;

  // Iterative divider states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Operand forwarding selects
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;

  // All four divide-family codes share the top two bits 11
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider: one quotient bit per cycle on operand
// magnitudes, sign correction applied when the result is read in DONE.
// Special cases (divide by zero, signed overflow) are handled by the caller
// and never reach this block.
module div_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            sign_op,
  input  logic            op_rem,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output div_state_e      state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            neg_q;
  logic            neg_r;
  logic            sel_rem;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  // Operand magnitudes for the signed variants
  assign a_neg = sign_op & a[XLEN-1];
  assign b_neg = sign_op & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One restoring step: shift next dividend bit into the partial remainder,
  // subtract the divisor and keep the difference only if it did not borrow.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[XLEN];
  assign rem_nxt = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nxt = {quo_q[XLEN-2:0], fits};

  // Divider FSM, iteration counter and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= BUSY;
            count   <= '0;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            sel_rem <= op_rem;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
            count <= '0;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            count <= count + 1'b1;
            if (count == LAST) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  // Sign-corrected quotient or remainder, meaningful in DONE
  always_comb begin
    result = '0;
    if (sel_rem) begin
      result = neg_r ? -rem_q : rem_q;
    end else begin
      result = neg_q ? -quo_q : quo_q;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative divider,
// branch-target adder and the EX/MEM pipeline register.
module exec_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            validE,
  input  logic            flushE,
  input  logic [3:0]      alu_controlE,
  input  logic            alu_srcE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] immExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PC_plus4E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] resultW,
  output logic            stallE,
  output logic            zeroE,
  output logic [XLEN-1:0] PC_targetE,
  output logic [XLEN-1:0] alu_resultM,
  output logic [XLEN-1:0] write_dataM,
  output logic [XLEN-1:0] PC_plus4M,
  output logic [4:0]      RdM,
  output logic            validM
);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] write_dataE;
  logic [XLEN-1:0] src_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] resultE;

  logic            is_div;
  logic            div_signed;
  logic            div_rem;
  logic            div_by_zero;
  logic            div_ovf;
  logic            div_special;
  logic [XLEN-1:0] special_result;
  logic            div_start;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_result;
  div_state_e      div_state;

  // Forwarding mux for operand A
  always_comb begin
    src_a = RD1E;
    case (forwardAE)
      FWD_RF:   src_a = RD1E;
      FWD_WB:   src_a = resultW;
      FWD_MEM:  src_a = alu_resultM;
      FWD_ZERO: src_a = '0;
      default:  src_a = '0;
    endcase
  end

  // Forwarding mux for operand B (also the store data, ahead of the immediate mux)
  always_comb begin
    write_dataE = RD2E;
    case (forwardBE)
      FWD_RF:   write_dataE = RD2E;
      FWD_WB:   write_dataE = resultW;
      FWD_MEM:  write_dataE = alu_resultM;
      FWD_ZERO: write_dataE = '0;
      default:  write_dataE = '0;
    endcase
  end

  assign src_b      = alu_srcE ? immExtE : write_dataE;
  assign shamt      = src_b[SHW-1:0];
  assign PC_targetE = PCE + immExtE;

  // Single-cycle ALU; divide codes and the reserved code yield zero here
  always_comb begin
    alu_result = '0;
    case (alu_controlE)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
      ALU_MUL:  alu_result = src_a * src_b;
      ALU_RSVD: alu_result = '0;
      default:  alu_result = '0;
    endcase
  end

  assign zeroE = (alu_result == '0);

  // Divide decode and the combinationally resolved special cases
  assign is_div      = is_div_op(alu_controlE);
  assign div_signed  = (alu_controlE == ALU_DIV) || (alu_controlE == ALU_REM);
  assign div_rem     = (alu_controlE == ALU_REM) || (alu_controlE == ALU_REMU);
  assign div_by_zero = (src_b == '0);
  assign div_ovf     = div_signed && (src_a == SMIN) && (src_b == '1);
  assign div_special = div_by_zero || div_ovf;

  // Special-case divide result: x/0 gives all ones (rem x); MIN/-1 gives MIN (rem 0)
  always_comb begin
    special_result = '0;
    if (div_by_zero) begin
      special_result = div_rem ? src_a : '1;
    end else if (div_ovf) begin
      special_result = div_rem ? '0 : src_a;
    end
  end

  // Start only from IDLE, so the divide still sitting in ID/EX during DONE cannot relaunch
  assign div_start = is_div && validE && !flushE && !div_special && (div_state == IDLE);
  assign stallE    = div_start || div_busy;

  div_iter #(
    .XLEN (XLEN)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .sign_op (div_signed),
    .op_rem  (div_rem),
    .a       (src_a),
    .b       (src_b),
    .flush   (flushE),
    .busy    (div_busy),
    .done    (div_done),
    .result  (div_result),
    .state   (div_state)
  );

  // Result selection: finished divide, special-case divide, or ALU
  always_comb begin
    resultE = alu_result;
    if (is_div) begin
      resultE = div_done ? div_result : special_result;
    end
  end

  // EX/MEM pipeline register; a stall or flush inserts a zeroed bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_resultM <= '0;
      write_dataM <= '0;
      PC_plus4M   <= '0;
      RdM         <= '0;
      validM      <= 1'b0;
    end else if (flushE || stallE) begin
      alu_resultM <= '0;
      write_dataM <= '0;
      PC_plus4M   <= '0;
      RdM         <= '0;
      validM      <= 1'b0;
    end else begin
      alu_resultM <= resultE;
      write_dataM <= write_dataE;
      PC_plus4M   <= PC_plus4E;
      RdM         <= RdE;
      validM      <= validE;
    end
  end

endmodule
